uart_rx_16: RTL and testbench

- 8N1 UART receiver that consumes the 16x oversampling tick from the baud tick generator (`b_16tick`, 1-clk pulse at BAUDRATE×16, 115200×16 at 100 MHz).
- Synchronises the asynchronous `rx` line and detects the start bit.
- Samples each bit at its centre by counting ticks, then delivers a byte with a one-cycle done strobe.
- Sits between the board RX pin and the command parser / FIFO of the plotter control path.

---
 rtl/uart_rx_16.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_16.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_16.sv
// 8N1 UART receiver driven by a 16x oversampling tick; samples each bit at its centre.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_16 #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_16tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Start detection is tick-independent so a back-to-back edge is caught at once.
                if (!rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (b_16tick) begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (b_16tick) begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (b_16tick) begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (b_16tick) begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        data_d  = shift_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^shift_q ^ par_q;
`endif
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_16.sv
// Directed scoreboard bench for uart_rx_16: frames, false start, framing error, back-to-back, reset abort.
module tb_uart_rx_16;

    localparam int TICK_DIV = 54;
    localparam int BIT_CLK  = TICK_DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b_16tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int dbl_cnt = 0;
    int tick_div = 0;
    logic done_prev = 1'b0;
    int first_cyc = 0;
    int last_cyc = 0;

    uart_rx_16 #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .b_16tick  (b_16tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_div == TICK_DIV - 1) begin
            b_16tick = 1'b1;
            tick_div = 0;
        end else begin
            b_16tick = 1'b0;
            tick_div = tick_div + 1;
        end
    end

    always @(negedge clk) begin
        rec_t r;
        cyc = cyc + 1;
        if (rx_busy) busy_cnt = busy_cnt + 1;
        if (rx_done) begin
            r.data = rx_data;
            r.ferr = frame_err;
`ifdef UART_RX_PARITY_EN
            r.perr = parity_err;
`else
            r.perr = 1'b0;
`endif
            r.cyc = cyc;
            obs_q.push_back(r);
            if (done_prev) dbl_cnt = dbl_cnt + 1;
        end
        done_prev = rx_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors = vectors + 1;
        assert (obs === expv) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic good_stop);
        rec_t e;
        e.data = d;
        e.ferr = ~good_stop;
        e.perr = ^d ^ par_bit;
        e.cyc  = 0;
        exp_q.push_back(e);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        wait_clk(BIT_CLK);
`endif
        if (good_stop) begin
            rx = 1'b1;
            wait_clk(BIT_CLK);
        end else begin
            // Low long enough to cover the mid-bit sample, then idle before the start re-check.
            rx = 1'b0;
            wait_clk(518);
            rx = 1'b1;
            wait_clk(BIT_CLK - 518);
        end
    endtask

    task automatic drain(input string tag);
        rec_t e, o;
        chk({tag, "_done_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            first_cyc = last_cyc;
            last_cyc = o.cyc;
            chk({tag, "_data"}, o.data, e.data);
            chk({tag, "_frame_err"}, o.ferr, e.ferr);
`ifdef UART_RX_PARITY_EN
            chk({tag, "_parity_err"}, o.perr, e.perr);
`endif
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_done"}, rx_done, 1'b0);
        chk({tag, "_rx_busy"}, rx_busy, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
`ifdef UART_RX_PARITY_EN
        chk({tag, "_parity_err"}, parity_err, 1'b0);
`endif
    endtask

    initial begin
        int b0, b1;
        logic [7:0] ab;
        wait_clk(5);
        chk_cleared("reset");
        rst = 1'b1;
        wait_clk(BIT_CLK);

        b0 = busy_cnt;
        send_frame(8'hA5, ^8'hA5, 1'b1);
        b1 = busy_cnt;
        chk("a5_busy_len", (b1 - b0 >= 8100 && b1 - b0 <= 8300), 1);
        chk("a5_busy_idle", rx_busy, 1'b0);
        drain("a5");
        chk("a5_hold", rx_data, 8'hA5);

        rx = 1'b0;
        wait_clk(100);
        chk("glitch_busy_on", rx_busy, 1'b1);
        wait_clk(100);
        rx = 1'b1;
        wait_clk(300);
        chk("glitch_busy_off", rx_busy, 1'b0);
        wait_clk(BIT_CLK);
        drain("glitch");

        send_frame(8'h3C, ^8'h3C, 1'b0);
        wait_clk(BIT_CLK);
        drain("badstop");
        send_frame(8'h81, ^8'h81, 1'b1);
        wait_clk(BIT_CLK);
        drain("clean81");
        chk("clean81_ferr_hold", frame_err, 1'b0);

        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        wait_clk(BIT_CLK);
        drain("b2b");
        chk("b2b_gap", last_cyc - first_cyc, NBITS * BIT_CLK);

        ab = 8'h11;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = ab[i];
            wait_clk(BIT_CLK);
        end
        rx = ab[4];
        wait_clk(400);
        chk("abort_busy_before", rx_busy, 1'b1);
        rst = 1'b0;
        wait_clk(2);
        chk_cleared("abort_rst");
        rx = 1'b1;
        wait_clk(20);
        rst = 1'b1;
        wait_clk(BIT_CLK);
        drain("abort");
        send_frame(8'h5A, ^8'h5A, 1'b1);
        wait_clk(BIT_CLK);
        drain("after_abort");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        drain("par_ok");
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        drain("par_bad");
`endif

        chk("done_pulse_width", dbl_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
